// File: rtl/cordic_pkg.sv
// Shared constants, scheduler state encoding and helpers for the CORDIC
// request scheduler.
package cordic_pkg;

  localparam int unsigned W         = 12;
  localparam int unsigned FXP_SHIFT = 10;
  localparam int unsigned FXP_MUL   = 1024;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    BUSY,
    RELEASE,
    RECOVER
  } sched_state_e;

  // Width of a requester index; never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_sched_if.sv
// Requester-side bus of the CORDIC scheduler: requests and angles in,
// id-tagged acknowledges and results out.
interface cordic_sched_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = cordic_pkg::W,
  localparam int unsigned IDW = cordic_pkg::id_width(N)
);

  logic [N-1:0]   req;
  logic [N*W-1:0] angle_in;
  logic [N-1:0]   ack;
  logic [W-1:0]   sin_out;
  logic [W-1:0]   cos_out;
  logic [IDW-1:0] result_id;
  logic           busy;
  logic           timeout_err;

  modport master (
    output req, angle_in,
    input  ack, sin_out, cos_out, result_id, busy, timeout_err
  );

  modport slave (
    input  req, angle_in,
    output ack, sin_out, cos_out, result_id, busy, timeout_err
  );

endinterface

// File: rtl/cordic_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at or after the
// pointer, pointer moves past the winner on grant_en_i.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IDW = cordic_pkg::id_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_i,
  input  logic           grant_en_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] grant_id_o,
  output logic           any_o
);
  import cordic_pkg::*;

  logic [IDW-1:0] ptr_q, ptr_d;

  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    any_o      = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + off) % N;
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o   = IDW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en_i && any_o)
      ptr_d = (32'(grant_id_o) == N - 1) ? '0 : grant_id_o + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cordic_sched.sv
// Shares one iterative sine/cosine CORDIC core among N requesters, with a
// watchdog that pulses the core reset when a job never completes.
module cordic_sched #(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = cordic_pkg::W,
  parameter int unsigned TIMEOUT = 512,
  parameter int unsigned RST_CYC = 2,
  localparam int unsigned IDW    = cordic_pkg::id_width(N)
) (
  input  logic         clock,
  input  logic         reset,
  cordic_sched_if.slave bus,
  output logic         core_start,
  output logic [W-1:0] core_angle,
  output logic         core_reset,
  input  logic         core_ready,
  input  logic [W-1:0] core_sin,
  input  logic [W-1:0] core_cos
);
  import cordic_pkg::*;

  localparam int unsigned WDW = $clog2(TIMEOUT);
  localparam int unsigned RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   angle_q, angle_d;
  logic [W-1:0]   sin_q, sin_d;
  logic [W-1:0]   cos_q, cos_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           rel_q, rel_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [RCW-1:0] rc_q, rc_d;

  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_any;
  logic           grant_en;
  logic [W-1:0]   angle_sel;
  logic [N-1:0]   ack_vec;
  logic           rst_pulse;
  logic           wd_hit;

  rr_arbiter #(.N(N)) u_arb (
    .clk        (clock),
    .rst        (reset),
    .req_i      (bus.req),
    .grant_en_i (grant_en),
    .grant_o    (grant),
    .grant_id_o (grant_id),
    .any_o      (grant_any)
  );

  always_comb begin
    angle_sel = '0;
    for (int unsigned k = 0; k < N; k++)
      if (grant[k]) angle_sel = bus.angle_in[k*W +: W];
  end

  assign wd_hit = (wd_q == WDW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    angle_d    = angle_q;
    sin_d      = sin_q;
    cos_d      = cos_q;
    busy_d     = busy_q;
    err_d      = err_q;
    rel_d      = rel_q;
    wd_d       = wd_q;
    rc_d       = rc_q;
    grant_en   = 1'b0;
    core_start = 1'b0;
    rst_pulse  = 1'b0;
    ack_vec    = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          grant_en = 1'b1;
          id_d     = grant_id;
          angle_d  = angle_sel;
          busy_d   = 1'b1;
          wd_d     = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // A ready still high here belongs to the previous job.
        core_start = 1'b1;
        wd_d       = wd_q + 1'b1;
        if (wd_hit) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          rc_d    = '0;
          state_d = RECOVER;
        end else if (!core_ready) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        core_start = 1'b1;
        wd_d       = wd_q + 1'b1;
        if (core_ready) begin
          sin_d   = core_sin;
          cos_d   = core_cos;
          rel_d   = 1'b0;
          state_d = RELEASE;
        end else if (wd_hit) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          rc_d    = '0;
          state_d = RECOVER;
        end
      end
      RELEASE: begin
        if (!rel_q) begin
          rel_d = 1'b1;
        end else begin
          ack_vec[id_q] = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end
      end
      RECOVER: begin
        rst_pulse = 1'b1;
        rc_d      = rc_q + 1'b1;
        if (rc_q == RCW'(RST_CYC - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      angle_q <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rel_q   <= 1'b0;
      wd_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      angle_q <= angle_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rel_q   <= rel_d;
      wd_q    <= wd_d;
      rc_q    <= rc_d;
    end
  end

  assign bus.ack         = ack_vec;
  assign bus.sin_out     = sin_q;
  assign bus.cos_out     = cos_q;
  assign bus.result_id   = id_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;
  assign core_angle      = angle_q;
  assign core_reset      = reset | rst_pulse;

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: behavioural CORDIC core beside the scheduler, and a
// round-robin order / ideal sin-cos reference checked per job.
module tb_cordic_sched;
  import cordic_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned TO  = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_sched_if #(.N(N), .W(W)) bus ();

  logic         core_start, core_reset, core_ready;
  logic [W-1:0] core_angle, core_sin, core_cos;

  cordic_sched #(.N(N), .W(W), .TIMEOUT(TO), .RST_CYC(2)) dut (
    .clock      (clk),
    .reset      (rst),
    .bus        (bus),
    .core_start (core_start),
    .core_angle (core_angle),
    .core_reset (core_reset),
    .core_ready (core_ready),
    .core_sin   (core_sin),
    .core_cos   (core_cos)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sx(input logic [W-1:0] v);
    return int'(signed'(v));
  endfunction

  function automatic int ideal(input logic [W-1:0] ang, input bit want_sin);
    real a, r;
    a = real'(sx(ang)) / real'(FXP_MUL);
    r = want_sin ? $sin(a) : $cos(a);
    return $rtoi($floor(r * 1024.0 + 0.5));
  endfunction

  function automatic logic [W-1:0] rand_angle();
    int v;
    v = int'($urandom_range(0, 3216)) - 1608;
    return W'(v);
  endfunction

  // Core model: load -> compute (random latency) -> done; done holds ready
  // until start drops. Results carry a +-1 LSB error like a real CORDIC.
  int           cst = 0;
  int           ccnt = 0;
  logic [W-1:0] cang = '0;
  bit           hang = 1'b0;
  always @(posedge clk) begin
    if (core_reset) begin
      cst        <= 0;
      ccnt       <= 0;
      core_ready <= 1'b0;
      core_sin   <= '0;
      core_cos   <= '0;
    end else begin
      case (cst)
        0: if (core_start) begin
          cst  <= 1;
          ccnt <= int'($urandom_range(2, 9));
          cang <= core_angle;
        end
        1: if (!hang) begin
          if (ccnt == 0) begin
            cst        <= 2;
            core_ready <= 1'b1;
            core_sin   <= W'(ideal(cang, 1'b1) + (cang[0] ? 1 : -1));
            core_cos   <= W'(ideal(cang, 1'b0) + (cang[1] ? 1 : -1));
          end else begin
            ccnt <= ccnt - 1;
          end
        end
        default: if (!core_start) begin
          cst        <= 0;
          core_ready <= 1'b0;
        end
      endcase
    end
  end

  // Reference round-robin order for a set of simultaneous requests.
  int mptr = 0;
  int exp_id[$];
  task automatic predict(input logic [N-1:0] mask);
    logic [N-1:0] p;
    p = mask;
    exp_id.delete();
    while (p != '0) begin
      for (int i = 0; i < N; i++) begin
        int idx;
        idx = (mptr + i) % N;
        if (p[idx]) begin
          exp_id.push_back(idx);
          p[idx] = 1'b0;
          mptr = (idx + 1) % N;
          break;
        end
      end
    end
  endtask

  // Collected acknowledges.
  int           q_id[$];
  int           q_rid[$];
  logic [N-1:0] q_ack[$];
  logic         q_busy[$];
  int           q_sin[$];
  int           q_cos[$];
  int           q_cyc[$];

  task automatic serve(input int njobs, input int budget, input logic [N-1:0] hold);
    int n;
    n = 0;
    q_id.delete(); q_rid.delete(); q_ack.delete(); q_busy.delete();
    q_sin.delete(); q_cos.delete(); q_cyc.delete();
    for (int c = 0; c < budget && n < njobs; c++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        int id;
        id = 0;
        for (int k = 0; k < N; k++) if (bus.ack[k]) id = k;
        q_id.push_back(id);
        q_rid.push_back(int'(bus.result_id));
        q_ack.push_back(bus.ack);
        q_busy.push_back(bus.busy);
        q_sin.push_back(sx(bus.sin_out));
        q_cos.push_back(sx(bus.cos_out));
        q_cyc.push_back(cyc);
        if (!hold[id]) bus.req[id] = 1'b0;
        n++;
      end
    end
    checks++;
    if (n != njobs) begin
      errors++;
      $display("FAIL serve_count: got %0d acks, required %0d", n, njobs);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.angle_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ack, bus.sin_out, bus.cos_out, bus.result_id, bus.busy, bus.timeout_err,
         core_start, core_angle} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%h sin=%h cos=%h id=%0d busy=%b err=%b start=%b angle=%h, required all 0",
               bus.ack, bus.sin_out, bus.cos_out, bus.result_id, bus.busy, bus.timeout_err,
               core_start, core_angle);
    end
    checks++;
    if (core_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_core_reset: got %b, required 1", core_reset);
    end
    rst = 1'b0;
    mptr = 0;
    @(negedge clk);
    checks++;
    if (core_reset !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: core_reset=%b busy=%b, required 0 0", core_reset, bus.busy);
    end
  endtask

  task automatic test_single();
    bus.angle_in[0 +: W] = 12'h324;
    predict(4'b0001);
    @(negedge clk);
    bus.req[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_grant: got %b, required 1", bus.busy);
    end
    serve(1, 100, '0);
    if (q_id.size() == 1) begin
      checks++;
      if (q_id[0] != 0 || q_rid[0] != 0 || q_busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL single_ack: id=%0d result_id=%0d busy=%b, required 0 0 1", q_id[0], q_rid[0], q_busy[0]);
      end
      checks++;
      if (q_sin[0] - 724 > 4 || q_sin[0] - 724 < -4 || q_cos[0] - 724 > 4 || q_cos[0] - 724 < -4) begin
        errors++;
        $display("FAIL single_result: sin=%0d cos=%0d, required 724+-4 both", q_sin[0], q_cos[0]);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.ack !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after_ack: ack=%h busy=%b, required 0 0", bus.ack, bus.busy);
    end
  endtask

  // Launch a simultaneous request set, then compare order and results.
  task automatic run_set(input string tag, input logic [N-1:0] mask, input logic [W-1:0] a0,
                         input logic [W-1:0] a1, input logic [W-1:0] a2, input logic [W-1:0] a3);
    logic [W-1:0] ang [N];
    ang[0] = a0; ang[1] = a1; ang[2] = a2; ang[3] = a3;
    @(negedge clk);
    for (int k = 0; k < N; k++) bus.angle_in[k*W +: W] = ang[k];
    bus.req = mask;
    predict(mask);
    serve($countones(mask), 600, '0);
    for (int i = 0; i < q_id.size() && i < exp_id.size(); i++) begin
      int es, ec;
      es = ideal(ang[exp_id[i]], 1'b1);
      ec = ideal(ang[exp_id[i]], 1'b0);
      checks++;
      if (q_id[i] != exp_id[i] || q_rid[i] != exp_id[i] || !$onehot(q_ack[i])) begin
        errors++;
        $display("FAIL %s_order[%0d]: ack=%h result_id=%0d, required id %0d", tag, i, q_ack[i], q_rid[i], exp_id[i]);
      end
      checks++;
      if (q_sin[i] - es > 4 || q_sin[i] - es < -4 || q_cos[i] - ec > 4 || q_cos[i] - ec < -4) begin
        errors++;
        $display("FAIL %s_result[%0d]: sin=%0d cos=%0d, required %0d %0d (+-4)", tag, i, q_sin[i], q_cos[i], es, ec);
      end
    end
  endtask

  task automatic test_all_four();
    apply_reset();
    run_set("all4", 4'b1111, 12'h000, 12'h192, 12'h324, 12'h648);
  endtask

  task automatic test_rotation();
    run_set("rot_a", 4'b0100, rand_angle(), rand_angle(), 12'h324, rand_angle());
    run_set("rot_b", 4'b1010, rand_angle(), 12'h192, rand_angle(), 12'h648);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a [3];
    int n, last;
    for (int j = 0; j < 3; j++) a[j] = rand_angle();
    n = 0;
    last = -100;
    @(negedge clk);
    bus.angle_in[W +: W] = a[0];
    bus.req[1] = 1'b1;
    mptr = 2;
    for (int c = 0; c < 300 && n < 3; c++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        int es, ec, s, co;
        es = ideal(a[n], 1'b1);
        ec = ideal(a[n], 1'b0);
        s  = sx(bus.sin_out);
        co = sx(bus.cos_out);
        checks++;
        if (bus.ack !== 4'b0010 || s - es > 4 || s - es < -4 || co - ec > 4 || co - ec < -4) begin
          errors++;
          $display("FAIL b2b_job[%0d]: ack=%h sin=%0d cos=%0d, required ack 2 sin %0d cos %0d (+-4)",
                   n, bus.ack, s, co, es, ec);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last < 4) begin
            errors++;
            $display("FAIL b2b_gap[%0d]: got %0d cycles, required >= 4", n, cyc - last);
          end
        end
        last = cyc;
        n++;
        if (n < 3) bus.angle_in[W +: W] = a[n];
        else       bus.req[1] = 1'b0;
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d acks, required 3", n);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      logic [N-1:0] mask;
      mask = N'($urandom_range(1, (1 << N) - 1));
      run_set("rand", mask, rand_angle(), rand_angle(), rand_angle(), rand_angle());
    end
  endtask

  task automatic test_hung();
    int  start_cyc, rst_cyc, early_acks, busy_in_rec, nack, got_id, s;
    bit  err_seen;
    start_cyc = 0; rst_cyc = 0; early_acks = 0; busy_in_rec = 0; nack = 0; got_id = -1; s = 0;
    err_seen = 1'b0;
    predict(4'b1000);
    hang = 1'b1;
    @(negedge clk);
    bus.angle_in[3*W +: W] = 12'h324;
    bus.req[3] = 1'b1;
    for (int c = 0; c < 900 && nack == 0; c++) begin
      @(negedge clk);
      if (!err_seen && bus.timeout_err) err_seen = 1'b1;
      if (!err_seen && core_start) start_cyc++;
      if (!err_seen && bus.ack != '0) early_acks++;
      if (core_reset) begin
        rst_cyc++;
        if (bus.busy) busy_in_rec++;
        hang = 1'b0;
      end
      if (err_seen && bus.ack != '0) begin
        nack++;
        for (int k = 0; k < N; k++) if (bus.ack[k]) got_id = k;
        s = sx(bus.sin_out);
        bus.req[3] = 1'b0;
      end
    end
    checks++;
    if (!err_seen || start_cyc != TO) begin
      errors++;
      $display("FAIL hung_timeout: err_seen=%b start_cycles=%0d, required 1 and %0d", err_seen, start_cyc, TO);
    end
    checks++;
    if (rst_cyc != 2 || busy_in_rec != 0) begin
      errors++;
      $display("FAIL hung_recover: core_reset cycles=%0d busy cycles=%0d, required 2 and 0", rst_cyc, busy_in_rec);
    end
    checks++;
    if (early_acks != 0) begin
      errors++;
      $display("FAIL hung_no_ack: got %0d acks for aborted job, required 0", early_acks);
    end
    checks++;
    if (nack != 1 || got_id != 3 || s - 724 > 4 || s - 724 < -4) begin
      errors++;
      $display("FAIL hung_reserve: acks=%0d id=%0d sin=%0d, required 1 3 724+-4", nack, got_id, s);
    end
    checks++;
    if (bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL hung_sticky: timeout_err=%b, required 1", bus.timeout_err);
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] a;
    int nb, es;
    a = rand_angle();
    nb = 0;
    @(negedge clk);
    bus.angle_in[2*W +: W] = a;
    bus.req[2] = 1'b1;
    for (int c = 0; c < 50 && nb < 2; c++) begin
      @(negedge clk);
      if (core_start) nb++;
    end
    checks++;
    if (nb != 2) begin
      errors++;
      $display("FAIL areset_reach_busy: start cycles=%0d, required 2", nb);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.ack, bus.sin_out, bus.cos_out, bus.result_id, bus.busy, bus.timeout_err,
         core_start, core_angle} !== '0 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL areset_outputs: ack=%h sin=%h cos=%h id=%0d busy=%b err=%b start=%b angle=%h core_reset=%b, required 0s and core_reset 1",
               bus.ack, bus.sin_out, bus.cos_out, bus.result_id, bus.busy, bus.timeout_err,
               core_start, core_angle, core_reset);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    predict(4'b0100);
    serve(1, 100, '0);
    es = ideal(a, 1'b1);
    if (q_id.size() == 1) begin
      checks++;
      if (q_id[0] != 2 || q_sin[0] - es > 4 || q_sin[0] - es < -4) begin
        errors++;
        $display("FAIL areset_reserve: id=%0d sin=%0d, required 2 and %0d (+-4)", q_id[0], q_sin[0], es);
      end
    end
  endtask

  initial begin
    bus.req = '0;
    bus.angle_in = '0;
    test_reset();
    test_single();
    test_all_four();
    test_rotation();
    test_back_to_back();
    test_random();
    test_hung();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
